accum_feeder: RTL
=================

ACCUM_FEEDER -- requirements
Module: accum_feeder

Interface
REQ-001 Parameter N, default 8: number of weight/input terms per evaluation; range 2..16.
REQ-002 Parameter WW, default 13: weight width, two's complement; equals accumulator feed width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 wload  input  1  write strobe; writes wdata into weight register waddr.
REQ-006 waddr  input  clog2(N)  weight register index.
REQ-007 wdata  input  WW  signed weight value.
REQ-008 start  input  1  request one evaluation; sampled only in IDLE.
REQ-009 xvec  input  N  input vector; bit i=1 means x_i=+1, bit i=0 means x_i=-1; latched on accepted start.
REQ-010 acc_clr  output  1  one-cycle clear pulse to the downstream accumulator.
REQ-011 feed  output  WW  unsigned magnitude |w_i| of the current term.
REQ-012 addflag  output  1  1 = add feed, 0 = subtract feed.
REQ-013 feed_valid  output  1  feed/addflag hold a valid term this cycle.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse; sum and sigma are valid.
REQ-016 sum  output  WW+1  signed, saturated local total of w_i*x_i.
REQ-017 sigma  output  1  1 when sum>0, else 0 (zero maps to -1).

Function
REQ-018 The FSM SHALL have states IDLE, CLEAR, STREAM, DONE.
REQ-019 IDLE + start=1 SHALL latch xvec, zero the internal sum, and go to CLEAR; start=0 stays in IDLE.
REQ-020 CLEAR SHALL last exactly one cycle with acc_clr=1, then go to STREAM with index 0.
REQ-021 STREAM SHALL last exactly N cycles, presenting term i on cycle i (i=0..N-1) with feed_valid=1; after i=N-1 it goes to DONE.
REQ-022 feed SHALL equal |w_i|; w=-2^(WW-1) yields 2^(WW-1), which fits unsigned WW bits.
REQ-023 addflag SHALL equal 1 when w_i*x_i>=0 (sign(w_i) XNOR x_i, with w_i=0 giving addflag=1, feed=0), else 0.
REQ-024 The internal sum SHALL add or subtract feed each STREAM cycle.
REQ-025 The sum SHALL saturate at +2^WW-1 and -2^WW instead of wrapping.
REQ-026 The sum and sigma outputs SHALL update only on entry to DONE and hold until the next DONE.
REQ-027 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-028 start while busy=1 SHALL be ignored; no queuing.
REQ-029 wload while busy=1 SHALL be ignored; wload in IDLE writes on that edge.
REQ-030 wload and start asserted in the same IDLE cycle SHALL both take effect; the written weight is used in that evaluation.
REQ-031 feed, addflag and acc_clr SHALL be 0 whenever feed_valid=0 and the state is not CLEAR.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 rst=0 SHALL asynchronously force IDLE; all weights, index, sum, sigma, feed, addflag, feed_valid, acc_clr, busy and done go to 0.
REQ-034 Reset during STREAM SHALL abort the evaluation; no done pulse follows reset release.
REQ-035 After rst returns to 1, the first accepted start SHALL behave as from power-up.

Verification
REQ-036 N=8, all w=11, xvec=8'hFF, start -> acc_clr on cycle 1; 8 cycles of feed=11, addflag=1; done with sum=88, sigma=1.
REQ-037 w0=-5, x0=+1; w1=7, x1=-1; rest w=0 -> term0 feed=5, addflag=0; term1 feed=7, addflag=0; zero terms feed=0, addflag=1; sum=-12, sigma=0.
REQ-038 All w=-4096, xvec=0 -> every term feed=4096, addflag=1; sum saturates to 8191, sigma=1.
REQ-039 Weights summing to 0 -> sum=0, sigma=0.
REQ-040 start pulsed mid-STREAM, and wload mid-STREAM -> exactly one done, weights unchanged, timing unchanged.
REQ-041 rst=0 at STREAM term 3 -> outputs 0 immediately; no done; a new start yields full CLEAR + 8 terms.

Source files
------------

// File: rtl/accum_feeder_if.sv
// Weight load, evaluation request and term-stream bundle
// for the accum_feeder sequencer.
interface accum_feeder_if #(
  parameter int N  = 8,
  parameter int WW = 13
);
  localparam int AW = (N > 1) ? $clog2(N) : 1;

  logic                 wload;
  logic [AW-1:0]        waddr;
  logic signed [WW-1:0] wdata;
  logic                 start;
  logic [N-1:0]         xvec;

  logic                 acc_clr;
  logic [WW-1:0]        feed;
  logic                 addflag;
  logic                 feed_valid;
  logic                 busy;
  logic                 done;
  logic signed [WW:0]   sum;
  logic                 sigma;

  modport master (
    output wload, waddr, wdata, start, xvec,
    input  acc_clr, feed, addflag, feed_valid,
    input  busy, done, sum, sigma
  );

  modport slave (
    input  wload, waddr, wdata, start, xvec,
    output acc_clr, feed, addflag, feed_valid,
    output busy, done, sum, sigma
  );
endinterface

// File: rtl/accum_feeder.sv
// Streams |w_i| with add/sub flags to an external accumulator
// and keeps a saturated local total plus its sign.
module accum_feeder #(
  parameter int N  = 8,
  parameter int WW = 13
) (
  input logic           clk,
  input logic           rst,
  accum_feeder_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = WW + 1;
  localparam int EW = WW + 2;
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic signed [EW-1:0] SMAX = {2'b00, {WW{1'b1}}};
  localparam logic signed [EW-1:0] SMIN = {2'b11, {WW{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    STREAM,
    DONE
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [IW-1:0]        idx_q;
  logic [IW-1:0]        idx_d;

  logic [WW-1:0]        w_q [N];
  logic [N-1:0]         x_q;
  logic signed [SW-1:0] acc_q;

  logic                 acc_clr_q;
  logic [WW-1:0]        feed_q;
  logic                 addflag_q;
  logic                 valid_q;
  logic                 busy_q;
  logic                 done_q;
  logic signed [SW-1:0] sum_q;
  logic                 sigma_q;

  logic                 accept;
  logic                 wr_en;
  logic [WW-1:0]        wsel;
  logic                 xsel;
  logic [WW-1:0]        mag_d;
  logic                 add_d;
  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] term;
  logic signed [EW-1:0] raw;
  logic signed [EW-1:0] sat;
  logic signed [SW-1:0] acc_nxt;

  assign accept = (state_q == IDLE) && bus.start;
  assign wr_en  = (state_q == IDLE) && bus.wload
               && (32'(bus.waddr) < 32'(N));

  assign bus.acc_clr    = acc_clr_q;
  assign bus.feed       = feed_q;
  assign bus.addflag    = addflag_q;
  assign bus.feed_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.sum        = sum_q;
  assign bus.sigma      = sigma_q;

  // State and term index register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state: one clear cycle, N stream cycles, one done cycle
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        state_d = STREAM;
        idx_d   = '0;
      end
      STREAM: begin
        if (idx_q == LAST) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Magnitude and direction of the term presented next cycle
  always_comb begin
    wsel  = w_q[idx_d];
    xsel  = x_q[idx_d];
    mag_d = wsel[WW-1] ? (~wsel + WW'(1)) : wsel;
    add_d = (wsel == '0) || (wsel[WW-1] ^ xsel);
  end

  // Saturating update of the local total with the current term
  always_comb begin
    ext  = {acc_q[SW-1], acc_q};
    term = {2'b00, feed_q};
    raw  = addflag_q ? (ext + term) : (ext - term);
    sat  = raw;
    if (raw > SMAX) begin
      sat = SMAX;
    end else if (raw < SMIN) begin
      sat = SMIN;
    end
    acc_nxt = sat[SW-1:0];
  end

  // Weight file writes in IDLE and input vector latch on start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        w_q[i] <= '0;
      end
      x_q <= '0;
    end else begin
      if (wr_en) begin
        w_q[bus.waddr] <= bus.wdata;
      end
      if (accept) begin
        x_q <= bus.xvec;
      end
    end
  end

  // Local total; published result only changes entering DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q   <= '0;
      sum_q   <= '0;
      sigma_q <= 1'b0;
    end else begin
      if (accept) begin
        acc_q <= '0;
      end else if (state_q == STREAM) begin
        acc_q <= acc_nxt;
      end
      if (state_q == STREAM && state_d == DONE) begin
        sum_q   <= acc_nxt;
        sigma_q <= !acc_nxt[SW-1] && (acc_nxt != '0);
      end
    end
  end

  // Registered outputs derived from the upcoming state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_clr_q <= 1'b0;
      feed_q    <= '0;
      addflag_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      acc_clr_q <= (state_d == CLEAR);
      valid_q   <= (state_d == STREAM);
      feed_q    <= (state_d == STREAM) ? mag_d : '0;
      addflag_q <= (state_d == STREAM) && add_d;
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
    end
  end
endmodule
